// File: rtl/snake_move_module_if.sv
// Signal bundle between the game controller / renderer side (master) and the
// snake motion engine (slave). Clock and reset stay outside the bundle.
interface snake_move_module_if #(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int MAX_LEN = 16
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [2:0]    Game_status;
    logic          Key_left;
    logic          Key_right;
    logic          Key_up;
    logic          Key_down;
    logic          Eat_sig;
    logic [XW-1:0] Query_x;
    logic [YW-1:0] Query_y;
    logic          Query_body;
    logic [XW-1:0] Head_x;
    logic [YW-1:0] Head_y;
    logic [LW-1:0] Snake_len;
    logic          Step_tick;
    logic          Hit_wall_sig;
    logic          Hit_body_sig;

    modport master (
        output Game_status, Key_left, Key_right, Key_up, Key_down, Eat_sig,
        output Query_x, Query_y,
        input  Query_body, Head_x, Head_y, Snake_len,
        input  Step_tick, Hit_wall_sig, Hit_body_sig
    );

    modport slave (
        input  Game_status, Key_left, Key_right, Key_up, Key_down, Eat_sig,
        input  Query_x, Query_y,
        output Query_body, Head_x, Head_y, Snake_len,
        output Step_tick, Hit_wall_sig, Hit_body_sig
    );
endinterface

// File: rtl/snake_move_module.sv
// Snake motion engine: steps the head on a fixed tick, shifts a bounded segment
// store, flags wall/self collisions and answers registered per-cell queries.
module snake_move_module #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int STEP_DIV = 12500000
) (
    input logic                Clk_50mhz,
    input logic                Rst_n,
    snake_move_module_if.slave bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic [XW-1:0] HOME_X   = XW'(GRID_W / 2);
    localparam logic [YW-1:0] HOME_Y   = YW'(GRID_H / 2);
    localparam logic [XW-1:0] X_LAST   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(GRID_H - 1);
    localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    localparam logic [2:0] ST_START = 3'b001;
    localparam logic [2:0] ST_PLAY  = 3'b010;

    // Opposite directions differ only in bit 0, so reversal is dir ^ 2'b01.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pend_dir_q, pend_dir_d;
    logic [1:0]    comm_dir_q, comm_dir_d;
    logic          grow_q, grow_d;
    logic          frozen_q, frozen_d;
    logic          tick_q, tick_d;
    logic          hit_wall_q, hit_wall_d;
    logic          hit_body_q, hit_body_d;
    logic          query_q, query_d;

    logic          is_start, is_play;
    logic          key_any;
    logic [1:0]    key_dir;
    logic          at_wall;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic [LW-1:0] body_lim;
    logic          body_hit;

    always_comb begin
        is_start = (bus.Game_status == ST_START);
        is_play  = (bus.Game_status == ST_PLAY);

        key_any = bus.Key_up | bus.Key_down | bus.Key_left | bus.Key_right;
        key_dir = DIR_RIGHT;
        if (bus.Key_up)        key_dir = DIR_UP;
        else if (bus.Key_down) key_dir = DIR_DOWN;
        else if (bus.Key_left) key_dir = DIR_LEFT;

        at_wall = 1'b0;
        next_x  = seg_x_q[0];
        next_y  = seg_y_q[0];
        case (pend_dir_q)
            DIR_UP: begin
                at_wall = (seg_y_q[0] == '0);
                next_y  = seg_y_q[0] - YW'(1);
            end
            DIR_DOWN: begin
                at_wall = (seg_y_q[0] == Y_LAST);
                next_y  = seg_y_q[0] + YW'(1);
            end
            DIR_LEFT: begin
                at_wall = (seg_x_q[0] == '0);
                next_x  = seg_x_q[0] - XW'(1);
            end
            default: begin
                at_wall = (seg_x_q[0] == X_LAST);
                next_x  = seg_x_q[0] + XW'(1);
            end
        endcase

        // The tail cell is only safe to enter when it is about to vacate.
        body_lim = grow_q ? len_q : (len_q - LW'(1));
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < body_lim) && (seg_x_q[i] == next_x) && (seg_y_q[i] == next_y))
                body_hit = 1'b1;
        end

        query_d = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_q) && (seg_x_q[i] == bus.Query_x) && (seg_y_q[i] == bus.Query_y))
                query_d = 1'b1;
        end
    end

    always_comb begin
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        pend_dir_d = pend_dir_q;
        comm_dir_d = comm_dir_q;
        grow_d     = grow_q;
        frozen_d   = frozen_q;
        tick_d     = 1'b0;
        hit_wall_d = 1'b0;
        hit_body_d = 1'b0;

        if (is_start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = (i < INIT_LEN) ? (HOME_X - XW'(i)) : '0;
                seg_y_d[i] = (i < INIT_LEN) ? HOME_Y : '0;
            end
            len_d      = LEN_INIT;
            cnt_d      = '0;
            pend_dir_d = DIR_RIGHT;
            comm_dir_d = DIR_RIGHT;
            grow_d     = 1'b0;
            frozen_d   = 1'b0;
        end else if (is_play) begin
            if (key_any && (key_dir != (comm_dir_q ^ 2'b01)))
                pend_dir_d = key_dir;
            if (bus.Eat_sig)
                grow_d = 1'b1;
            if (!frozen_q) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (at_wall) begin
                        frozen_d   = 1'b1;
                        hit_wall_d = 1'b1;
                    end else if (body_hit) begin
                        frozen_d   = 1'b1;
                        hit_body_d = 1'b1;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = next_x;
                        seg_y_d[0] = next_y;
                        if (grow_q && (len_q < LEN_MAX))
                            len_d = len_q + LW'(1);
                        grow_d     = 1'b0;
                        comm_dir_d = pend_dir_q;
                        tick_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk_50mhz) begin
        if (!Rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? (HOME_X - XW'(i)) : '0;
                seg_y_q[i] <= (i < INIT_LEN) ? HOME_Y : '0;
            end
            len_q      <= LEN_INIT;
            cnt_q      <= '0;
            pend_dir_q <= DIR_RIGHT;
            comm_dir_q <= DIR_RIGHT;
            grow_q     <= 1'b0;
            frozen_q   <= 1'b0;
            tick_q     <= 1'b0;
            hit_wall_q <= 1'b0;
            hit_body_q <= 1'b0;
            query_q    <= 1'b0;
        end else begin
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            pend_dir_q <= pend_dir_d;
            comm_dir_q <= comm_dir_d;
            grow_q     <= grow_d;
            frozen_q   <= frozen_d;
            tick_q     <= tick_d;
            hit_wall_q <= hit_wall_d;
            hit_body_q <= hit_body_d;
            query_q    <= query_d;
        end
    end

    assign bus.Head_x       = seg_x_q[0];
    assign bus.Head_y       = seg_y_q[0];
    assign bus.Snake_len    = len_q;
    assign bus.Step_tick    = tick_q;
    assign bus.Hit_wall_sig = hit_wall_q;
    assign bus.Hit_body_sig = hit_body_q;
    assign bus.Query_body   = query_q;
endmodule
